regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: two requester write queues (A, B) share the single
// regfile write port. At most one entry is popped per cycle. A lone non-empty
// queue always wins; on a tie the queue not granted last time wins. The write
// is registered, so an entry pushed at edge N is popped at N+1 and written at N+2.
module regfile_wr_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic [4:0]  wraddr,
  output logic [31:0] wrdata,
  output logic        RegWrite,
  output logic        idle
);
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  localparam int NQ = 2;                 // queue 0 = A, queue 1 = B
  localparam int EW = $bits(wr_req_t);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;            // count reaches DEPTH, needs one extra bit

  logic [NQ-1:0]         push, pop, empty, ready;
  logic [NQ-1:0][EW-1:0] din, head;
  wr_req_t               hsel;
  logic                  last_grant;     // 0 = A, 1 = B

  assign din[0] = {a_addr, a_data};
  assign din[1] = {b_addr, b_data};
  // ready is purely registered, so gating the push with it adds no input->output path
  assign push   = {b_valid & ready[1], a_valid & ready[0]};

  for (genvar q = 0; q < NQ; q++) begin : g_q
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;

    // entry storage; validity is defined by the pointers, so no reset needed
    always_ff @(posedge clock) begin
      if (push[q]) mem[wptr] <= din[q];
    end

    // pointers wrap for free because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push[q]) wptr <= wptr + AW'(1);
        if (pop[q])  rptr <= rptr + AW'(1);
        case ({push[q], pop[q]})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: ;
        endcase
      end
    end

    assign head[q]  = mem[rptr];
    assign empty[q] = (cnt == '0);
    assign ready[q] = (cnt < CW'(DEPTH));
  end

  // grant: lone non-empty queue wins; on a tie pick the one not granted last
  always_comb begin
    pop = '0;
    if (!empty[0] && (empty[1] || last_grant)) pop[0] = 1'b1;
    else if (!empty[1])                        pop[1] = 1'b1;
  end

  assign hsel = wr_req_t'(pop[1] ? head[1] : head[0]);

  // write port register; address 0 is consumed but never written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      wraddr     <= '0;
      wrdata     <= '0;
      RegWrite   <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      if (|pop) begin
        last_grant <= pop[1];
        wraddr     <= hsel.addr;
        wrdata     <= hsel.data;
        RegWrite   <= (hsel.addr != 5'd0);
      end
    end
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];
  assign idle    = (&empty) & ~RegWrite;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed stimulus pushes hand-ordered expected
// writes into a queue; a monitor pops and compares on every RegWrite.
module tb_regfile_wr_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  logic        RegWrite, idle;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_e;
  logic [31:0] rf [32] = '{default: '0};

  always #5 clock = ~clock;

  regfile_wr_arbiter #(.DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wraddr(wraddr), .wrdata(wrdata), .RegWrite(RegWrite), .idle(idle)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // regfile stand-in: records every write, including any to address 0
  always @(posedge clock) begin
    if (RegWrite === 1'b1) rf[wraddr] <= wrdata;
  end

  // monitor: every presented write must match the next expected entry
  always @(negedge clock) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h want none", wraddr, wrdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(wraddr), 32'(mon_e[36:32]));
        chk("wr_data", wrdata, mon_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clr();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  task automatic drive_a(input logic [4:0] ad, input logic [31:0] d);
    a_valid = 1'b1; a_addr = ad; a_data = d;
  endtask

  task automatic drive_b(input logic [4:0] ad, input logic [31:0] d);
    b_valid = 1'b1; b_addr = ad; b_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] ad, input logic [31:0] d);
    exp_q.push_back({ad, d});
  endtask

  // returns at a negedge with reset just released; the next edge may push
  task automatic do_reset();
    tick();
    reset = 1'b0;
    clr();
    repeat (2) tick();
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || idle !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ai, bi;
    logic ra, rb;
    reset = 1'b1;
    clr();
    #2 reset = 1'b0;

    // reset state
    tick();
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wraddr", 32'(wraddr), 32'd0);
    chk("rst_wrdata", wrdata, 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    tick();

    // single write; push on the very edge after reset release
    reset = 1'b1;
    drive_a(5'd1, 32'd100);
    expect_wr(5'd1, 32'd100);
    tick();
    clr();
    chk("t1_no_bypass", 32'(RegWrite), 32'd0);
    chk("t1_busy", 32'(idle), 32'd0);
    chk("t1_a_ready", 32'(a_ready), 32'd1);
    drain("t1");
    chk("t1_rf1", rf[1], 32'd100);

    // tie after reset goes to A; next tie (last grant A) goes to B
    do_reset();
    expect_wr(5'd4, 32'd5);
    expect_wr(5'd8, 32'd333);
    expect_wr(5'd6, 32'd66);
    expect_wr(5'd9, 32'd99);
    drive_a(5'd4, 32'd5);
    drive_b(5'd8, 32'd333);
    tick();
    drive_a(5'd6, 32'd66);
    drive_b(5'd9, 32'd99);
    tick();
    clr();
    chk("t2_b_full", 32'(b_ready), 32'd0);
    chk("t2_a_ready", 32'(a_ready), 32'd1);
    drain("t2");

    // three back-to-back A pushes, written in order one per cycle
    expect_wr(5'd10, 32'h111);
    expect_wr(5'd11, 32'h222);
    expect_wr(5'd12, 32'h333);
    chk("t3_a_ready0", 32'(a_ready), 32'd1);
    drive_a(5'd10, 32'h111);
    tick();
    chk("t3_a_ready1", 32'(a_ready), 32'd1);
    drive_a(5'd11, 32'h222);
    tick();
    chk("t3_a_ready2", 32'(a_ready), 32'd1);
    chk("t3_wr0", 32'(RegWrite), 32'd1);
    drive_a(5'd12, 32'h333);
    tick();
    clr();
    chk("t3_wr1", 32'(RegWrite), 32'd1);
    tick();
    chk("t3_wr2", 32'(RegWrite), 32'd1);
    drain("t3");

    // address 0: consumed, no write
    drive_b(5'd0, 32'd2000);
    tick();
    clr();
    chk("t4_queued", 32'(idle), 32'd0);
    tick();
    chk("t4_regwrite", 32'(RegWrite), 32'd0);
    chk("t4_wraddr", 32'(wraddr), 32'd0);
    chk("t4_wrdata", wrdata, 32'd2000);
    chk("t4_consumed", 32'(idle), 32'd1);
    drain("t4");
    chk("t4_rf0", rf[0], 32'd0);

    // reset mid-operation: B refilled to full, A drained, entry 21 in flight
    do_reset();
    expect_wr(5'd20, 32'h2020);
    expect_wr(5'd22, 32'h2222);
    expect_wr(5'd21, 32'h2121);
    drive_a(5'd20, 32'h2020);
    drive_b(5'd22, 32'h2222);
    tick();
    drive_a(5'd21, 32'h2121);
    drive_b(5'd23, 32'h2323);
    tick();
    a_valid = 1'b0;
    drive_b(5'd24, 32'h2424);
    chk("t5_b_full", 32'(b_ready), 32'd0);
    chk("t5_a_ready", 32'(a_ready), 32'd1);
    tick();
    chk("t5_b_rise", 32'(b_ready), 32'd1);
    tick();
    chk("t5_b_refull", 32'(b_ready), 32'd0);
    chk("t5_a_drained", 32'(a_ready), 32'd1);
    chk("t5_inflight", 32'(RegWrite), 32'd1);
    #2 reset = 1'b0;
    clr();
    #1;
    chk("t5_rst_regwrite", 32'(RegWrite), 32'd0);
    chk("t5_rst_idle", 32'(idle), 32'd1);
    chk("t5_rst_a_ready", 32'(a_ready), 32'd1);
    chk("t5_rst_b_ready", 32'(b_ready), 32'd1);
    chk("t5_rst_wraddr", 32'(wraddr), 32'd0);
    chk("t5_rst_wrdata", wrdata, 32'd0);
    chk("t5_pre_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("t5_idle_after", 32'(idle), 32'd1);
    chk("t5_rf20", rf[20], 32'h2020);
    chk("t5_rf22", rf[22], 32'h2222);
    chk("t5_rf21", rf[21], 32'd0);
    chk("t5_rf23", rf[23], 32'd0);
    chk("t5_rf24", rf[24], 32'd0);

    // both requesters streaming for 8 cycles: strict A/B alternation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      expect_wr(5'(1 + i), 32'hA000 + 32'(i));
      expect_wr(5'(6 + i), 32'hB000 + 32'(i));
    end
    ai = 0;
    bi = 0;
    for (int c = 0; c < 8; c++) begin
      drive_a(5'(1 + ai), 32'hA000 + 32'(ai));
      drive_b(5'(6 + bi), 32'hB000 + 32'(bi));
      if (c >= 2) chk("t6_regwrite", 32'(RegWrite), 32'd1);
      ra = a_ready;
      rb = b_ready;
      tick();
      if (ra) ai++;
      if (rb) bi++;
    end
    clr();
    for (int c = 0; c < 4; c++) begin
      chk("t6_regwrite_tail", 32'(RegWrite), 32'd1);
      tick();
    end
    chk("t6_a_accepted", 32'(ai), 32'd5);
    chk("t6_b_accepted", 32'(bi), 32'd5);
    chk("t6_stop", 32'(RegWrite), 32'd0);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
